sevenseg_mux_n: RTL

Parametrised N-digit multiplexed seven-segment driver, the next generation of the team's 4-digit display mux. Time-multiplexes DIGITS BCD/hex nibbles onto shared active-low segment lines with active-low anodes. Adds:
- a frame-coherent shadow register, so no tearing
- optional leading-zero blanking
- hex or BCD decode
- per-digit decimal points
- 16-level brightness PWM
- a frame tick for upstream logic, such as the frequency counter's display update

---
 rtl/sevenseg_mux_n.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sevenseg_mux_n.sv
// -----------------------------------------------------------------------------
// sevenseg_mux_n
//
// N-digit time-multiplexed seven-segment driver.
// Each digit owns a slot of 2^DIV_W clocks. One frame is DIGITS slots.
// At every frame boundary the digit and decimal-point inputs are copied into
// a shadow register, so a frame never mixes old and new values.
//
// Parameters
//   DIGITS     number of digits (2..8); digit 0 is rightmost, an[0]
//   DIV_W      slot counter width (>= 4); slot length is 2^DIV_W clocks
//
// Ports
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   digits     4*DIGITS nibbles, digit i = digits[4i+3:4i]
//   dp_in      per-digit decimal point request, 1 = lit
//   blank_lz   1 = blank leading zeros (digit 0 is never blanked)
//   hex_en     1 = show 10..15 as A,b,C,d,E,F; 0 = show a dash
//   brightness PWM duty, anode on for (brightness+1)/16 of each slot
//   seg        {g,f,e,d,c,b,a}, active-low, registered
//   dp         decimal point, active-low, registered
//   an         anode enables, active-low, at most one low, registered
//   frame_tick one-clock pulse after each frame boundary, registered
// -----------------------------------------------------------------------------
module sevenseg_mux_n #(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  hex_en,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int SEL_W = $clog2(DIGITS);

    logic [DIV_W-1:0]    slot_cnt_reg;
    logic [SEL_W-1:0]    sel_reg;
    logic [4*DIGITS-1:0] shadow_digits_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;

    logic slot_end;
    logic last_sel;
    logic frame_end;

    assign slot_end  = &slot_cnt_reg;
    assign last_sel  = (sel_reg == SEL_W'(DIGITS - 1));
    assign frame_end = slot_end && last_sel;

    // -------------------------------------------------------------------------
    // Slot counter, digit index and frame-coherent shadow
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_reg      <= '0;
            sel_reg           <= '0;
            shadow_digits_reg <= '0;
            shadow_dp_reg     <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + DIV_W'(1);
            if (slot_end) begin
                sel_reg <= last_sel ? '0 : sel_reg + SEL_W'(1);
            end
            // Loading on the boundary clock makes the new values visible from
            // the first slot of the following frame.
            if (frame_end) begin
                shadow_digits_reg <= digits;
                shadow_dp_reg     <= dp_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero detection: zero_above[i] is set when every shadow nibble
    // from the top digit down to digit i is zero.
    // -------------------------------------------------------------------------
    logic [DIGITS-1:0] zero_above;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            assign zero_above[gi] = (shadow_digits_reg[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Selected-digit mux
    // -------------------------------------------------------------------------
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic [DIGITS-1:0] an_onehot;

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_reg == SEL_W'(i)) begin
                cur_nib      = shadow_digits_reg[4*i +: 4];
                cur_dp       = shadow_dp_reg[i];
                cur_blank    = blank_lz && (i != 0) && zero_above[i];
                an_onehot[i] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Segment decode, {g,f,e,d,c,b,a}, 0 = lit
    // -------------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        if (!hex && (v > 4'd9)) begin
            s = 7'b0111111;
        end
        return s;
    endfunction

    // PWM phase is the top four bits of the slot counter, so the duty cycle
    // is independent of DIV_W.
    logic [3:0] phase;
    logic       lit;

    assign phase = slot_cnt_reg[DIV_W-1 -: 4];
    assign lit   = (phase <= brightness);

    // -------------------------------------------------------------------------
    // Registered outputs (one-cycle pipeline behind sel/slot_cnt)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= cur_blank ? 7'b1111111 : decode(cur_nib, hex_en);
            dp         <= ~cur_dp;
            an         <= lit ? ~an_onehot : '1;
            frame_tick <= frame_end;
        end
    end

endmodule
